// File: rtl/weight_prefetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : weight_prefetch_ctrl
// Description : Weight fetch-and-stream controller for the Winograd CNN
//               datapath. It latches the layer configuration and fetches one
//               weight tile covering two output-depth slots (TAPS lanes each)
//               from the weight memory. The tile is held until started, then
//               streamed to the PE array with backpressure for a configurable
//               number of accepted beats.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset         : clock; asynchronous active-low reset
//   cfg_*              : layer configuration, latched on cfg_wen_i in IDLE
//   od1_i, od2_i, id_i : slot 0 / slot 1 output depth and input depth
//   prepare_i          : fetch request (IDLE, or READY to replace the tile)
//   start_i            : stream request (READY only)
//   ready_o            : a complete tile is buffered
//   err_o              : one-cycle pulse on a rejected prepare_i
//   mem_req_o          : one-cycle read strobe, mem_addr_o valid with it
//   mem_addr_o         : per-lane read address (0 on inactive lanes)
//   mem_valid_i/addr_i/data_i : per-lane response with echoed address
//   pe_valid_o         : tile is being presented to the PE array
//   pe_ready_i         : PE array accepts the current beat
//   pe_lane_en_o       : active-lane mask while streaming
//   pe_data_o          : per-lane weights while streaming (0 when inactive)
// ============================================================================
module weight_prefetch_ctrl #(
    parameter  int TAPS   = 9,
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 16,
    parameter  int OD_W   = 8,
    parameter  int ID_W   = 4,
    localparam int LANES  = 2 * TAPS
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           cfg_wen_i,
    input  logic [ID_W-1:0]                cfg_total_id_i,
    input  logic [OD_W-1:0]                cfg_total_od_i,
    input  logic                           cfg_size_type_i,
    input  logic [ADDR_W-1:0]              cfg_base_i,
    input  logic [7:0]                     cfg_reuse_i,

    input  logic [OD_W-1:0]                od1_i,
    input  logic [OD_W-1:0]                od2_i,
    input  logic [ID_W-1:0]                id_i,
    input  logic                           prepare_i,
    input  logic                           start_i,
    output logic                           ready_o,
    output logic                           err_o,

    output logic                           mem_req_o,
    output logic [LANES-1:0][ADDR_W-1:0]   mem_addr_o,
    input  logic [LANES-1:0]               mem_valid_i,
    input  logic [LANES-1:0][ADDR_W-1:0]   mem_addr_i,
    input  logic [LANES-1:0][DATA_W-1:0]   mem_data_i,

    output logic                           pe_valid_o,
    input  logic                           pe_ready_i,
    output logic [LANES-1:0]               pe_lane_en_o,
    output logic [LANES-1:0][DATA_W-1:0]   pe_data_o
);

    // Wide enough that (od*total_id + id)*TAPS + t + base never overflows
    // before the final truncation to ADDR_W.
    localparam int FULL_W = ADDR_W + OD_W + ID_W + $clog2(TAPS) + 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREPARE = 2'd1,
        ST_READY   = 2'd2,
        ST_STREAM  = 2'd3
    } state_t;

    state_t                       state_q,     state_d;
    logic [ID_W-1:0]              total_id_q,  total_id_d;
    logic [OD_W-1:0]              total_od_q,  total_od_d;
    logic                         size_type_q, size_type_d;
    logic [ADDR_W-1:0]            base_q,      base_d;
    logic [7:0]                   reuse_q,     reuse_d;
    logic [LANES-1:0][ADDR_W-1:0] addr_q,      addr_d;
    logic [LANES-1:0]             act_q,       act_d;
    logic [LANES-1:0]             cap_q,       cap_d;
    logic [LANES-1:0][DATA_W-1:0] data_q,      data_d;
    logic [7:0]                   beat_q,      beat_d;
    logic                         err_q,       err_d;
    logic                         mem_req_q,   mem_req_d;

    logic [LANES-1:0]             req_act;
    logic [LANES-1:0][ADDR_W-1:0] req_addr;
    logic [1:0]                   slot_ok;
    logic                         prep_ok;
    logic                         take_prep;
    logic                         streaming;

    // ------------------------------------------------------------------
    // Requested lane mask and addresses for the indices currently on the
    // inputs, evaluated against the latched configuration. Lane index is
    // slot*TAPS + tap.
    // ------------------------------------------------------------------
    for (genvar s = 0; s < 2; s++) begin : g_slot
        logic [OD_W-1:0]   od_sel;
        logic [FULL_W-1:0] row;

        assign od_sel     = (s == 0) ? od1_i : od2_i;
        assign slot_ok[s] = (od_sel < total_od_q);
        assign row        = FULL_W'(od_sel) * FULL_W'(total_id_q) + FULL_W'(id_i);

        for (genvar t = 0; t < TAPS; t++) begin : g_tap
            logic lane_act;

            // A 1x1 kernel only uses tap 0 of each slot.
            assign lane_act = slot_ok[s] & (~size_type_q | (t == 0));
            assign req_act[s*TAPS+t] = lane_act;
            assign req_addr[s*TAPS+t] = !lane_act ? '0 :
                size_type_q ? ADDR_W'(FULL_W'(base_q) + row)
                            : ADDR_W'(FULL_W'(base_q) + row * FULL_W'(TAPS) + FULL_W'(t));
        end
    end

    assign prep_ok = (id_i < total_id_q) && (|req_act);

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        total_id_d  = total_id_q;
        total_od_d  = total_od_q;
        size_type_d = size_type_q;
        base_d      = base_q;
        reuse_d     = reuse_q;
        addr_d      = addr_q;
        act_d       = act_q;
        cap_d       = cap_q;
        data_d      = data_q;
        beat_d      = beat_q;
        err_d       = 1'b0;
        mem_req_d   = 1'b0;
        take_prep   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_wen_i) begin
                    total_id_d  = cfg_total_id_i;
                    total_od_d  = cfg_total_od_i;
                    size_type_d = cfg_size_type_i;
                    base_d      = cfg_base_i;
                    reuse_d     = cfg_reuse_i;
                end
                // The fetch uses the configuration already latched, not a
                // value being written in the same cycle.
                if (prepare_i) begin
                    if (prep_ok) take_prep = 1'b1;
                    else         err_d     = 1'b1;
                end
            end

            ST_PREPARE: begin
                // Only an active lane whose echo matches its own request is
                // accepted; repeats simply overwrite the stored word.
                for (int l = 0; l < LANES; l++) begin
                    if (mem_valid_i[l] && act_q[l] && (mem_addr_i[l] == addr_q[l])) begin
                        cap_d[l]  = 1'b1;
                        data_d[l] = mem_data_i[l];
                    end
                end
                if (cap_d == act_q) state_d = ST_READY;
            end

            ST_READY: begin
                // A new prepare replaces the buffered tile and takes
                // priority over start; a rejected one leaves the tile held.
                if (prepare_i) begin
                    if (prep_ok) take_prep = 1'b1;
                    else         err_d     = 1'b1;
                end else if (start_i) begin
                    state_d = ST_STREAM;
                    beat_d  = (reuse_q == 8'd0) ? 8'd1 : reuse_q;
                end
            end

            ST_STREAM: begin
                if (pe_ready_i) begin
                    if (beat_q <= 8'd1) begin
                        state_d = ST_IDLE;
                        addr_d  = '0;
                        act_d   = '0;
                        cap_d   = '0;
                        data_d  = '0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q - 8'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (take_prep) begin
            state_d   = ST_PREPARE;
            addr_d    = req_addr;
            act_d     = req_act;
            cap_d     = '0;
            data_d    = '0;
            mem_req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            total_id_q  <= '0;
            total_od_q  <= '0;
            size_type_q <= 1'b0;
            base_q      <= '0;
            reuse_q     <= '0;
            addr_q      <= '0;
            act_q       <= '0;
            cap_q       <= '0;
            data_q      <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_id_q  <= total_id_d;
            total_od_q  <= total_od_d;
            size_type_q <= size_type_d;
            base_q      <= base_d;
            reuse_q     <= reuse_d;
            addr_q      <= addr_d;
            act_q       <= act_d;
            cap_q       <= cap_d;
            data_q      <= data_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign streaming    = (state_q == ST_STREAM);
    assign ready_o      = (state_q == ST_READY);
    assign err_o        = err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = addr_q;
    assign pe_valid_o   = streaming;
    assign pe_lane_en_o = streaming ? act_q : '0;

    always_comb begin
        pe_data_o = '0;
        for (int l = 0; l < LANES; l++) begin
            if (streaming && act_q[l]) pe_data_o[l] = data_q[l];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_prefetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_prefetch_ctrl
// Description : Self-checking bench for weight_prefetch_ctrl. Expected lane
//               masks, addresses and data come from a transaction-level model
//               built from the addressing and sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_prefetch_ctrl;

    localparam int TAPS   = 9;
    localparam int LANES  = 2 * TAPS;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int OD_W   = 8;
    localparam int ID_W   = 4;
    localparam int CW     = 512;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         cfg_wen_i;
    logic [ID_W-1:0]              cfg_total_id_i;
    logic [OD_W-1:0]              cfg_total_od_i;
    logic                         cfg_size_type_i;
    logic [ADDR_W-1:0]            cfg_base_i;
    logic [7:0]                   cfg_reuse_i;
    logic [OD_W-1:0]              od1_i, od2_i;
    logic [ID_W-1:0]              id_i;
    logic                         prepare_i, start_i;
    logic                         ready_o, err_o, mem_req_o;
    logic [LANES-1:0][ADDR_W-1:0] mem_addr_o;
    logic [LANES-1:0]             mem_valid_i;
    logic [LANES-1:0][ADDR_W-1:0] mem_addr_i;
    logic [LANES-1:0][DATA_W-1:0] mem_data_i;
    logic                         pe_valid_o, pe_ready_i;
    logic [LANES-1:0]             pe_lane_en_o;
    logic [LANES-1:0][DATA_W-1:0] pe_data_o;

    weight_prefetch_ctrl #(
        .TAPS(TAPS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OD_W(OD_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_wen_i(cfg_wen_i), .cfg_total_id_i(cfg_total_id_i),
        .cfg_total_od_i(cfg_total_od_i), .cfg_size_type_i(cfg_size_type_i),
        .cfg_base_i(cfg_base_i), .cfg_reuse_i(cfg_reuse_i),
        .od1_i(od1_i), .od2_i(od2_i), .id_i(id_i),
        .prepare_i(prepare_i), .start_i(start_i),
        .ready_o(ready_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_valid_i(mem_valid_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .pe_valid_o(pe_valid_o), .pe_ready_i(pe_ready_i),
        .pe_lane_en_o(pe_lane_en_o), .pe_data_o(pe_data_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: latched configuration and the tile the bench expects to be held.
    int                           m_tid, m_tod, m_st, m_base, m_reuse;
    logic [LANES-1:0]             exp_act, nxt_act;
    logic [LANES-1:0][ADDR_W-1:0] exp_addr, nxt_addr;
    logic [LANES-1:0][DATA_W-1:0] exp_data;
    bit                           tile_held;

    task automatic chk_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        mem_valid_i = '0;
    endtask

    task automatic put_resp(input int l, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_valid_i[l] = 1'b1;
        mem_addr_i[l]  = a;
        mem_data_i[l]  = d;
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_ready"},   CW'(ready_o),      '0);
        chk_eq({tag, "_err"},     CW'(err_o),        '0);
        chk_eq({tag, "_memreq"},  CW'(mem_req_o),    '0);
        chk_eq({tag, "_memaddr"}, CW'(mem_addr_o),   '0);
        chk_eq({tag, "_pevalid"}, CW'(pe_valid_o),   '0);
        chk_eq({tag, "_laneen"},  CW'(pe_lane_en_o), '0);
        chk_eq({tag, "_pedata"},  CW'(pe_data_o),    '0);
    endtask

    task automatic model_reset();
        m_tid = 0; m_tod = 0; m_st = 0; m_base = 0; m_reuse = 0;
        exp_act = '0; exp_addr = '0; exp_data = '0; tile_held = 1'b0;
    endtask

    task automatic set_cfg(input int tid, input int tod, input int st, input int base, input int reuse);
        cfg_total_id_i  = ID_W'(tid);
        cfg_total_od_i  = OD_W'(tod);
        cfg_size_type_i = (st != 0);
        cfg_base_i      = ADDR_W'(base);
        cfg_reuse_i     = 8'(reuse);
        cfg_wen_i       = 1'b1;
        step();
        cfg_wen_i = 1'b0;
        m_tid = tid; m_tod = tod; m_st = st; m_base = base; m_reuse = reuse;
    endtask

    // Lane mask and addresses straight from the addressing formula.
    function automatic bit plan(input int od1, input int od2, input int id);
        int     ods[2];
        longint a;
        ods[0] = od1;
        ods[1] = od2;
        nxt_act  = '0;
        nxt_addr = '0;
        for (int s = 0; s < 2; s++) begin
            for (int t = 0; t < TAPS; t++) begin
                if (ods[s] < m_tod && (m_st == 0 || t == 0)) begin
                    if (m_st != 0) a = longint'(m_base) + longint'(ods[s]) * m_tid + id;
                    else           a = longint'(m_base) + (longint'(ods[s]) * m_tid + id) * TAPS + t;
                    nxt_act[s*TAPS+t]  = 1'b1;
                    nxt_addr[s*TAPS+t] = ADDR_W'(a % (longint'(1) << ADDR_W));
                end
            end
        end
        return (id < m_tid) && (nxt_act != '0);
    endfunction

    function automatic int pick_od(input int tod);
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 255));
        return int'($urandom_range(0, (tod < 255) ? tod : 254));
    endfunction

    task automatic do_prepare(input int od1, input int od2, input int id, input bit start_too, output bit ok);
        ok        = plan(od1, od2, id);
        od1_i     = OD_W'(od1);
        od2_i     = OD_W'(od2);
        id_i      = ID_W'(id);
        prepare_i = 1'b1;
        start_i   = start_too && ok;
        step();
        prepare_i = 1'b0;
        start_i   = 1'b0;
        if (ok) begin
            exp_act   = nxt_act;
            exp_addr  = nxt_addr;
            exp_data  = '0;
            tile_held = 1'b0;
            chk_eq("prep_memreq",  CW'(mem_req_o),  CW'(1));
            chk_eq("prep_err",     CW'(err_o),      '0);
            chk_eq("prep_addr",    CW'(mem_addr_o), CW'(exp_addr));
            chk_eq("prep_ready",   CW'(ready_o),    '0);
            chk_eq("prep_pevalid", CW'(pe_valid_o), '0);
        end else begin
            chk_eq("reject_err",    CW'(err_o),     CW'(1));
            chk_eq("reject_memreq", CW'(mem_req_o), '0);
            chk_eq("reject_ready",  CW'(ready_o),   CW'(tile_held));
            step();
            chk_eq("err_one_cycle", CW'(err_o),     '0);
        end
    endtask

    // Returns every active lane in random groups, mixed with wrong echoes,
    // echoes to inactive lanes, duplicates and stray start_i pulses.
    task automatic respond();
        int               pend[$];
        logic [LANES-1:0] got, drv;
        logic [DATA_W-1:0] d;
        int               k, l, j, tmp, guard;
        for (int i = 0; i < LANES; i++) if (exp_act[i]) pend.push_back(i);
        for (int i = pend.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = pend[i]; pend[i] = pend[j]; pend[j] = tmp;
        end
        got = '0;
        guard = 0;
        while (pend.size() > 0 && guard < 64) begin
            drv = '0;
            k = int'($urandom_range(1, 4));
            for (int i = 0; i < k && pend.size() > 0; i++) begin
                l = pend.pop_front();
                d = DATA_W'($urandom);
                put_resp(l, exp_addr[l], d);
                exp_data[l] = d;
                got[l] = 1'b1;
                drv[l] = 1'b1;
            end
            if (pend.size() > 0 && $urandom_range(0, 2) == 0)
                put_resp(pend[0], exp_addr[pend[0]] ^ ADDR_W'(1 << $urandom_range(0, ADDR_W - 1)),
                         DATA_W'($urandom));
            l = int'($urandom_range(0, LANES - 1));
            if (!exp_act[l] && $urandom_range(0, 1) == 0)
                put_resp(l, exp_addr[l], DATA_W'($urandom));
            l = int'($urandom_range(0, LANES - 1));
            if (got[l] && !drv[l] && $urandom_range(0, 2) == 0) begin
                d = DATA_W'($urandom);
                put_resp(l, exp_addr[l], d);
                exp_data[l] = d;
            end
            start_i = ($urandom_range(0, 3) == 0);
            step();
            clear_mem();
            start_i = 1'b0;
            guard++;
            chk_eq("ready_vs_capture", CW'(ready_o), CW'(pend.size() == 0));
        end
        if (pend.size() > 0) chk_eq("capture_timeout", CW'(pend.size()), '0);
        tile_held = 1'b1;
    endtask

    // Matching responses while READY must not alter the buffered tile.
    task automatic stray(input int n);
        for (int i = 0; i < n; i++) begin
            mem_valid_i = '1;
            mem_addr_i  = exp_addr;
            for (int l = 0; l < LANES; l++) mem_data_i[l] = DATA_W'($urandom);
            step();
            clear_mem();
            chk_eq("stray_ready",   CW'(ready_o),    CW'(1));
            chk_eq("stray_pevalid", CW'(pe_valid_o), '0);
        end
    endtask

    task automatic do_stream(input logic [7:0] pat, input int pat_len, input bit junk);
        int beats, cyc;
        bit r;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        tile_held = 1'b0;
        chk_eq("start_pevalid", CW'(pe_valid_o),   CW'(1));
        chk_eq("start_ready",   CW'(ready_o),      '0);
        chk_eq("start_laneen",  CW'(pe_lane_en_o), CW'(exp_act));
        chk_eq("start_pedata",  CW'(pe_data_o),    CW'(exp_data));
        beats = (m_reuse == 0) ? 1 : m_reuse;
        cyc = 0;
        while (beats > 0 && cyc < 2000) begin
            r = (cyc < pat_len) ? pat[cyc] : ($urandom_range(0, 9) < 6);
            pe_ready_i = r;
            if (junk) begin
                prepare_i       = 1'($urandom_range(0, 1));
                start_i         = 1'($urandom_range(0, 1));
                cfg_wen_i       = 1'($urandom_range(0, 1));
                cfg_total_id_i  = ID_W'($urandom);
                cfg_total_od_i  = OD_W'($urandom);
                cfg_size_type_i = 1'($urandom);
                cfg_base_i      = ADDR_W'($urandom);
                cfg_reuse_i     = 8'($urandom);
                mem_valid_i     = LANES'($urandom);
                mem_addr_i      = exp_addr;
            end
            step();
            pe_ready_i = 1'b0; prepare_i = 1'b0; start_i = 1'b0; cfg_wen_i = 1'b0;
            clear_mem();
            if (r) beats--;
            cyc++;
            if (beats > 0) begin
                chk_eq("stream_pevalid", CW'(pe_valid_o), CW'(1));
                chk_eq("stream_hold",    CW'(pe_data_o),  CW'(exp_data));
            end else begin
                chk_eq("end_pevalid", CW'(pe_valid_o),   '0);
                chk_eq("end_ready",   CW'(ready_o),      '0);
                chk_eq("end_laneen",  CW'(pe_lane_en_o), '0);
                chk_eq("end_pedata",  CW'(pe_data_o),    '0);
            end
        end
        if (beats > 0) chk_eq("stream_timeout", CW'(beats), '0);
        chk_eq("end_memreq", CW'(mem_req_o), '0);
        chk_eq("end_err",    CW'(err_o),     '0);
        exp_act = '0; exp_addr = '0; exp_data = '0;
    endtask

    initial begin
        bit                ok;
        logic [DATA_W-1:0] d;

        reset = 1'b0;
        cfg_wen_i = 1'b0; cfg_total_id_i = '0; cfg_total_od_i = '0; cfg_size_type_i = 1'b0;
        cfg_base_i = '0; cfg_reuse_i = '0; od1_i = '0; od2_i = '0; id_i = '0;
        prepare_i = 1'b0; start_i = 1'b0; pe_ready_i = 1'b0;
        mem_valid_i = '0; mem_addr_i = '0; mem_data_i = '0;
        model_reset();
        step(); step();
        check_all_zero("por");
        reset = 1'b1;
        step();

        // Full two-slot tile.
        set_cfg(4, 8, 0, 16'h0100, 1);
        do_prepare(2, 3, 1, 1'b0, ok);
        chk_eq("tp1_lane0",  CW'(mem_addr_o[0]),  CW'(16'h0151));
        chk_eq("tp1_lane8",  CW'(mem_addr_o[8]),  CW'(16'h0159));
        chk_eq("tp1_lane9",  CW'(mem_addr_o[9]),  CW'(16'h0175));
        chk_eq("tp1_lane17", CW'(mem_addr_o[17]), CW'(16'h017D));
        respond();
        do_stream(8'h00, 0, 1'b0);

        // Slot 1 out of range.
        do_prepare(2, 8, 1, 1'b0, ok);
        chk_eq("tp2_mask",   CW'(exp_act),        CW'(18'h001FF));
        chk_eq("tp2_lane9",  CW'(mem_addr_o[9]),  '0);
        respond();
        do_stream(8'h00, 0, 1'b0);

        // 1x1 kernel.
        set_cfg(4, 8, 1, 16'h0100, 1);
        do_prepare(2, 3, 1, 1'b0, ok);
        chk_eq("tp3_lane0", CW'(mem_addr_o[0]), CW'(16'h0109));
        chk_eq("tp3_lane9", CW'(mem_addr_o[9]), CW'(16'h010D));
        chk_eq("tp3_lane1", CW'(mem_addr_o[1]), '0);
        respond();
        do_stream(8'h00, 0, 1'b0);

        // reuse = 3 with PE ready pattern 1,0,1,1.
        set_cfg(4, 8, 0, 16'h0100, 3);
        do_prepare(2, 3, 1, 1'b0, ok);
        respond();
        do_stream(8'b0000_1101, 4, 1'b0);

        // Lane 4 echoes a wrong address first.
        set_cfg(4, 8, 0, 16'h0100, 1);
        do_prepare(2, 8, 1, 1'b0, ok);
        for (int l = 0; l < TAPS; l++) begin
            if (l != 4) begin
                d = DATA_W'($urandom);
                put_resp(l, exp_addr[l], d);
                exp_data[l] = d;
            end
        end
        step(); clear_mem();
        chk_eq("tp5_partial", CW'(ready_o), '0);
        put_resp(4, exp_addr[4] ^ 16'h0004, DATA_W'($urandom));
        step(); clear_mem();
        chk_eq("tp5_wrong_echo", CW'(ready_o), '0);
        step();
        chk_eq("tp5_gap", CW'(ready_o), '0);
        d = DATA_W'($urandom);
        put_resp(4, exp_addr[4], d);
        exp_data[4] = d;
        step(); clear_mem();
        chk_eq("tp5_complete", CW'(ready_o), CW'(1));
        tile_held = 1'b1;
        do_stream(8'h00, 0, 1'b0);
        do_prepare(2, 3, 4, 1'b0, ok);   // id == total_id

        // Reset in the middle of a fetch.
        set_cfg(4, 8, 0, 16'h0100, 2);
        do_prepare(2, 3, 1, 1'b0, ok);
        for (int l = 0; l < 5; l++) put_resp(l, exp_addr[l], DATA_W'($urandom));
        step(); clear_mem();
        chk_eq("tp6_partial", CW'(ready_o), '0);
        reset = 1'b0;
        #2;
        check_all_zero("async_reset");
        step();
        reset = 1'b1;
        model_reset();
        do_prepare(0, 0, 0, 1'b0, ok);   // configuration was cleared
        set_cfg(4, 8, 0, 16'h0100, 2);
        do_prepare(2, 3, 1, 1'b0, ok);
        respond();
        do_stream(8'h00, 0, 1'b0);

        // Randomized tiles.
        for (int it = 0; it < 40; it++) begin
            int tid, tod;
            tid = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
            tod = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 255));
            set_cfg(tid, tod, ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 65535)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 40)) : int'($urandom_range(0, 5)));
            do_prepare(pick_od(tod), pick_od(tod), int'($urandom_range(0, tid)), 1'b0, ok);
            if (ok) begin
                respond();
                if ($urandom_range(0, 1) == 1) stray(int'($urandom_range(1, 2)));
                if ($urandom_range(0, 2) == 0) begin
                    do_prepare(pick_od(tod), pick_od(tod), int'($urandom_range(0, tid)),
                               1'($urandom_range(0, 1)), ok);
                    if (ok) respond();
                end
                do_stream(8'h00, 0, 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
